// File: rtl/ul_dfe_ant_sched_pkg.sv
// ul_dfe_ant_sched_pkg: shared state enum, sample type and next-enabled-antenna search
package ul_dfe_ant_sched_pkg;
  localparam int MAX_ANT = 8;
  localparam int DEF_PRECISION = 16;
  typedef enum logic [1:0] {IDLE, ALIGN, EMIT, APPLY} state_e;
  typedef logic [2*DEF_PRECISION-1:0] sample_t;
  function automatic logic [3:0] next_idx(input logic [MAX_ANT-1:0] mask, input logic [3:0] from);
    next_idx = 4'(MAX_ANT);
    for (int i = MAX_ANT - 1; i >= 0; i--) if (mask[i] && 4'(i) >= from) next_idx = 4'(i);
  endfunction
endpackage

// File: rtl/ul_dfe_ant_sched_fifo.sv
// ul_dfe_ant_sched_fifo: show-ahead sync FIFO (clk_4x, rst_4x, flush, wr/din, rd/dout, full, empty, multi = holds 2+ entries)
module ul_dfe_ant_sched_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_4x,
  input  logic         rst_4x,
  input  logic         flush,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         multi
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_rd, do_wr;
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign multi = cnt > (AW+1)'(1);
  assign dout = mem[rp];
  always_ff @(posedge clk_4x)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk_4x) begin
    if (rst_4x || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_wr ? wp + AW'(1) : wp;
      rp <= do_rd ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

// File: rtl/ul_dfe_ant_tdm_sched.sv
// ul_dfe_ant_tdm_sched: per-antenna FIFOs aligned into one AXI-stream (cfg_*, clr_ovf, s_tvalid/s_tdata in; m_t* out with m_tready; active_mask, ovf_sticky status)
module ul_dfe_ant_tdm_sched
  import ul_dfe_ant_sched_pkg::*;
#(
  parameter int N_ANTENNAS = 4,
  parameter int PRECISION = 16,
  parameter int USR_ID_BW = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clk_4x,
  input  logic                                    rst_4x,
  input  logic [N_ANTENNAS-1:0]                   cfg_ant_en,
  input  logic                                    cfg_update,
  input  logic                                    clr_ovf,
  input  logic [N_ANTENNAS-1:0]                   s_tvalid,
  input  logic [N_ANTENNAS-1:0][2*PRECISION-1:0]  s_tdata,
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic [2*PRECISION-1:0]                  m_tdata,
  output logic [USR_ID_BW-1:0]                    m_tuser,
  output logic                                    m_tlast,
  output logic [N_ANTENNAS-1:0]                   active_mask,
  output logic [N_ANTENNAS-1:0]                   ovf_sticky
);
  state_e state, state_nxt;
  logic pend, pend_now, hs, flush, load, clr_valid, ld_last, rdy_now, rdy_next;
  logic [N_ANTENNAS-1:0] pend_mask, wr, pop, full, empty, multi;
  logic [2*PRECISION-1:0] dout [N_ANTENNAS];
  logic [2*PRECISION-1:0] ld_data;
  logic [MAX_ANT-1:0] mask8;
  logic [3:0] first_idx, nxt_idx, ld_idx;
  assign hs = m_tvalid & m_tready;
  assign wr = s_tvalid & active_mask;
  assign flush = state == APPLY;
  assign pend_now = pend | cfg_update;
  assign mask8 = MAX_ANT'(active_mask);
  assign first_idx = next_idx(mask8, 4'd0);
  assign nxt_idx = next_idx(mask8, 4'(m_tuser) + 4'd1);
  assign ld_last = next_idx(mask8, ld_idx + 4'd1) == 4'(MAX_ANT);
  assign rdy_now = ~|(active_mask & empty);
  // the lane being popped on the closing beat must still hold its next-round sample
  assign rdy_next = ~|(active_mask & ((pop & ~multi) | (~pop & empty)));
  for (genvar a = 0; a < N_ANTENNAS; a++) begin : g_lane
    assign pop[a] = hs && m_tuser == USR_ID_BW'(a);
    ul_dfe_ant_sched_fifo #(.W(2*PRECISION), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_4x(clk_4x),
      .rst_4x(rst_4x),
      .flush(flush),
      .wr(wr[a]),
      .din(s_tdata[a]),
      .rd(pop[a]),
      .dout(dout[a]),
      .full(full[a]),
      .empty(empty[a]),
      .multi(multi[a])
    );
  end
  always_comb begin
    ld_data = '0;
    for (int i = 0; i < N_ANTENNAS; i++) if (ld_idx == 4'(i)) ld_data = dout[i];
  end
  always_comb begin
    state_nxt = state;
    load = 1'b0;
    clr_valid = 1'b0;
    ld_idx = first_idx;
    case (state)
      IDLE: state_nxt = pend_now ? APPLY : IDLE;
      ALIGN: begin
        if (pend_now) state_nxt = APPLY;
        else if (rdy_now) begin
          state_nxt = EMIT;
          load = 1'b1;
        end
      end
      EMIT: begin
        if (hs) begin
          if (!m_tlast) begin
            load = 1'b1;
            ld_idx = nxt_idx;
          end else if (pend_now) begin
            state_nxt = APPLY;
            clr_valid = 1'b1;
          end else if (rdy_next) load = 1'b1;
          else begin
            state_nxt = ALIGN;
            clr_valid = 1'b1;
          end
        end
      end
      APPLY: state_nxt = |pend_mask ? ALIGN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_4x) begin
    if (rst_4x) begin
      state <= IDLE;
      pend <= 1'b0;
      pend_mask <= '0;
      active_mask <= '0;
      ovf_sticky <= '0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tuser <= '0;
      m_tlast <= 1'b0;
    end else begin
      state <= state_nxt;
      pend <= cfg_update | (pend & ~flush);
      pend_mask <= cfg_update ? cfg_ant_en : pend_mask;
      active_mask <= flush ? pend_mask : active_mask;
      // a fresh overflow beats a simultaneous clear
      ovf_sticky <= (ovf_sticky & ~{N_ANTENNAS{clr_ovf}}) | (wr & full & ~pop & ~{N_ANTENNAS{flush}});
      if (load) begin
        m_tvalid <= 1'b1;
        m_tdata <= ld_data;
        m_tuser <= USR_ID_BW'(ld_idx);
        m_tlast <= ld_last;
      end else if (clr_valid) m_tvalid <= 1'b0;
    end
  end
endmodule

// File: doc/ul_dfe_ant_tdm_sched.md
# ul_dfe_ant_tdm_sched

Time-division scheduler for the UL DFE antenna serialiser path. It buffers per-antenna complex samples arriving at 1x rate on the 4x clock and aligns them so that every serial round carries the same time index from each enabled antenna. It emits them as a single AXI-stream with antenna ID and end-of-round marker, and applies antenna-enable reconfiguration only on round boundaries.

## Interface
- N_ANTENNAS, 4: number of antenna lanes (2..8)
- PRECISION, 16: bits per I/Q component; sample width 2*PRECISION
- USR_ID_BW, 2: antenna ID width; must satisfy 2**USR_ID_BW >= N_ANTENNAS
- FIFO_DEPTH, 4: per-antenna buffer depth (power of 2, >= 2)

Ports:
- clk_4x  in  1  4x processing clock; the only clock
- rst_4x  in  1  synchronous, active-high reset
- cfg_ant_en  in  N_ANTENNAS  requested antenna enable mask
- cfg_update  in  1  one-cycle pulse; request to apply cfg_ant_en
- clr_ovf  in  1  one-cycle pulse; clears ovf_sticky
- s_tvalid  in  N_ANTENNAS  per-antenna sample valid; no backpressure upstream
- s_tdata  in  2*PRECISION x N_ANTENNAS  per-antenna sample {I,Q}
- m_tvalid  out  1  serial output valid
- m_tready  in  1  downstream ready
- m_tdata  out  2*PRECISION  serial sample
- m_tuser  out  USR_ID_BW  antenna index of m_tdata
- m_tlast  out  1  last enabled antenna of the round
- active_mask  out  N_ANTENNAS  mask currently in force
- ovf_sticky  out  N_ANTENNAS  per-antenna drop flag

## Operation
- Each antenna has a FIFO. A write occurs when s_tvalid[i] is high and active_mask[i] is set. Inputs of disabled antennas are ignored.
- A write to a full FIFO drops the sample and sets ovf_sticky[i]. If clr_ovf and a new overflow occur in the same cycle, the set wins.
- FSM states:
  - IDLE: active_mask == 0.
  - ALIGN: waits until every enabled FIFO is non-empty.
  - EMIT: a slot pointer walks the enabled antennas in ascending index order. Each handshake (m_tvalid && m_tready) pops one FIFO and advances the pointer.
  - APPLY: one cycle. Loads the pending mask, flushes all FIFOs and clears pending.
- cfg_update sets a pending flag and captures cfg_ant_en. Pending is acted on only from IDLE or ALIGN, or after the m_tlast handshake, by going to APPLY. A mid-round update never truncates a round.
- APPLY exits to IDLE if the new mask is 0, otherwise to ALIGN. An update with an identical mask still flushes, which forces realignment.
- After the m_tlast handshake, the FSM goes to APPLY if pending is set.
  - Otherwise, if all enabled FIFOs are non-empty, the first slot of the next round is presented in the next cycle with no bubble.
  - Otherwise it goes to ALIGN.
- m_tuser is the absolute antenna index, not the slot ordinal. m_tlast is high on the highest enabled index.
- The output is a registered AXI source: while m_tvalid is high and m_tready is low, m_tdata, m_tuser and m_tlast stay stable.
- A FIFO receiving a write in the same cycle it is popped keeps its occupancy. A write to a full FIFO in the same cycle as a pop is accepted.

## Timing
- Reset values: m_tvalid 0, m_tdata 0, m_tuser 0, m_tlast 0, active_mask 0, ovf_sticky 0. FSM in IDLE, FIFOs empty, pending 0.
- Reset mid-round discards all buffered data. The first cycle after reset deassertion behaves as IDLE.
- Latency: all enabled antennas written at cycle t into empty FIFOs gives m_tvalid high at cycle t+2 with the lowest enabled antenna.
- Throughput: one sample per cycle while m_tready is high. N_ANTENNAS enabled lanes at 1/N_ANTENNAS input rate each are sustained with zero overflow.
- cfg_update in IDLE or ALIGN at cycle t: APPLY at t+1, active_mask updated at t+2.

## Structure
- Package ul_dfe_ant_sched_pkg holds:
  - state enum {IDLE, ALIGN, EMIT, APPLY}
  - sample typedef logic [2*PRECISION-1:0]
  - next-enabled-index function (priority search above the current pointer)
- Sub-module ul_dfe_ant_sched_fifo: synchronous FIFO with flush input, full/empty flags and show-ahead read data. One instance per antenna, built with generate.

## Test plan
- Mask 4'b1111, all lanes valid every 4th cycle with data 0x1000+ant, m_tready=1: m_tuser sequence 0,1,2,3 repeating, m_tlast only with tuser=3, no ovf.
- Mask 4'b1010: only tuser 1,3 emitted, m_tlast with tuser=3; s_tvalid on lanes 0,2 has no effect.
- Hold m_tready=0 for 12 cycles mid-round with FIFO_DEPTH=4: outputs stable; ovf_sticky[i] is set only on lanes written while full; the emission sequence resumes in order.
- cfg_update to 4'b0011 while emitting tuser=1 of a 4'b1111 round: tuser 2,3 still emitted; APPLY follows m_tlast; the next round is 0,1 with m_tlast on 1.
- Lane 2 starved while others valid: m_tvalid stays 0 in ALIGN until lane 2 writes, then emission starts 2 cycles later.
- Assert rst_4x during EMIT: next cycle all outputs are at their reset values and active_mask is 0.
